// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and register map for mmio_uart_tx
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;
  localparam logic [1:0] REG_INTEN    = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO, combinational head read, pushes when full and pops when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO; UART_TX_IRQ_EN adds irq and INTEN
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 2,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [3:0]            mem_mask_write,
  input  logic [ADDR_WIDTH-1:0] addr_write,
  input  logic [ADDR_WIDTH-1:0] addr_read,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  uart_tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   r_baud_div;
  logic          r_overflow;
  logic [31:0]   r_data_out;
  logic          r_uart_tx;
  tx_state_t     r_state;
  logic [15:0]   r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;

  logic          w_push_req, w_push, w_pop, w_full, w_empty;
  logic          w_ovf_set, w_ovf_clr;
  logic [CW-1:0] w_count;
  logic [7:0]    w_fifo_rdata;
  logic [15:0]   w_reload;
  logic [31:0]   w_status, w_rd_data, w_inten_rd;
  logic          w_unused;

  assign w_unused   = ^{data_in[31:16], mem_mask_write[3:2]};
  assign w_push_req = write_enable && (addr_write[1:0] == REG_TXDATA) && mem_mask_write[0];
  assign w_push     = w_push_req && !w_full;
  assign w_ovf_set  = w_push_req && w_full;
  assign w_ovf_clr  = write_enable && (addr_write[1:0] == REG_STATUS) && mem_mask_write[0]
                      && data_in[STAT_OVF];
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_reload   = (r_baud_div == 16'd0) ? 16'd0 : (r_baud_div - 16'd1);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_wdata (data_in[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_baud_div <= DEFAULT_DIV;
      r_overflow <= 1'b0;
    end else begin
      if (write_enable && (addr_write[1:0] == REG_BAUD_DIV)) begin
        if (mem_mask_write[0]) r_baud_div[7:0]  <= data_in[7:0];
        if (mem_mask_write[1]) r_baud_div[15:8] <= data_in[15:8];
      end
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
    end
  end

  // baud_cnt is reloaded from the live register at every bit start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_shift    <= w_fifo_rdata;
          r_bit_cnt  <= 3'd0;
          r_baud_cnt <= w_reload;
          r_state    <= ST_START;
        end
        ST_START: if (r_baud_cnt == 16'd0) begin
          r_baud_cnt <= w_reload;
          r_bit_cnt  <= 3'd0;
          r_state    <= ST_DATA;
        end else r_baud_cnt <= r_baud_cnt - 16'd1;
        ST_DATA: if (r_baud_cnt == 16'd0) begin
          r_baud_cnt <= w_reload;
          r_shift    <= r_shift >> 1;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= ST_STOP;
        end else r_baud_cnt <= r_baud_cnt - 16'd1;
        ST_STOP: if (r_baud_cnt == 16'd0) r_state <= ST_IDLE;
          else r_baud_cnt <= r_baud_cnt - 16'd1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_uart_tx <= 1'b1;
    else begin
      case (r_state)
        ST_START: r_uart_tx <= 1'b0;
        ST_DATA:  r_uart_tx <= r_shift[0];
        default:  r_uart_tx <= 1'b1;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_inten;
  logic r_irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inten <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (write_enable && (addr_write[1:0] == REG_INTEN) && mem_mask_write[0])
        r_inten <= data_in[0];
      r_irq <= r_inten && w_empty && (r_state == ST_IDLE);
    end
  end

  assign irq        = r_irq;
  assign w_inten_rd = {31'd0, r_inten};
`else
  assign w_inten_rd = 32'd0;
`endif

  always_comb begin
    w_status                       = 32'd0;
    w_status[STAT_FULL]            = w_full;
    w_status[STAT_EMPTY]           = w_empty;
    w_status[STAT_BUSY]            = (r_state != ST_IDLE);
    w_status[STAT_OVF]             = r_overflow;
    w_status[STAT_COUNT_LSB +: CW] = w_count;
  end

  always_comb begin
    w_rd_data = 32'd0;
    case (addr_read[1:0])
      REG_STATUS:   w_rd_data = w_status;
      REG_BAUD_DIV: w_rd_data = {16'd0, r_baud_div};
      REG_INTEN:    w_rd_data = w_inten_rd;
      default:      w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)            r_data_out <= 32'd0;
    else if (read_enable) r_data_out <= w_rd_data;
  end

  assign data_out = r_data_out;
  assign uart_tx  = r_uart_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx: serial-line receiver and read-data monitor
module tb_mmio_uart_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [3:0]  mem_mask_write;
  logic [1:0]  addr_write;
  logic [1:0]  addr_read;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        uart_tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  mmio_uart_tx #(.ADDR_WIDTH(2), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
    .clock          (clock),
    .reset          (reset),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .mem_mask_write (mem_mask_write),
    .addr_write     (addr_write),
    .addr_read      (addr_read),
    .data_in        (data_in),
    .data_out       (data_out),
    .uart_tx        (uart_tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [15:0] model_div = 16'd868;
  logic [7:0]  exp_q[$];
  bit          b2b_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  bit          mon_en   = 1'b1;
  bit          mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Receiver: captures a whole frame from its start bit and compares it with the queued byte.
  initial begin : uart_mon
    logic       prev;
    logic       samp [0:1023];
    int         d, start, last_start;
    bit         have_last, shape_ok, bb;
    logic [7:0] rx, eb;
    prev = 1'b1;
    have_last = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en && prev && !uart_tx && !reset) begin
        mon_busy = 1'b1;
        d = (model_div == 16'd0) ? 1 : int'(model_div);
        start = cyc;
        samp[0] = uart_tx;
        for (int i = 1; i < 10 * d; i++) begin
          @(negedge clock);
          samp[i] = uart_tx;
        end
        shape_ok = (samp[0] === 1'b0) && (samp[9 * d] === 1'b1);
        for (int k = 0; k < 10; k++)
          for (int c = 0; c < d; c++)
            if (samp[k * d + c] !== samp[k * d]) shape_ok = 1'b0;
        for (int k = 0; k < 8; k++) rx[k] = samp[(k + 1) * d];
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got byte 0x%02h, required no frame", rx);
        end else begin
          eb = exp_q.pop_front();
          bb = b2b_q.pop_front();
          check("frame_byte", 32'(rx), 32'(eb));
          check("frame_shape", 32'(shape_ok), 32'd1);
          if (bb && have_last) check("frame_gap", start - last_start, 10 * d + 1);
        end
        last_start = start;
        have_last = 1'b1;
        prev = uart_tx;
        mon_busy = 1'b0;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin : read_mon
    forever begin
      @(posedge clock);
      if (read_enable && !reset) begin
        @(negedge clock);
        if (rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_read: got 0x%08h, required no read", data_out);
        end else check(rd_name_q.pop_front(), data_out, rd_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
    write_enable = 1'b1;
    addr_write = a;
    mem_mask_write = m;
    data_in = d;
    if (a == 2'd2) begin
      if (m[0]) model_div[7:0]  = d[7:0];
      if (m[1]) model_div[15:8] = d[15:8];
    end
    @(negedge clock);
    write_enable = 1'b0;
    mem_mask_write = 4'd0;
    data_in = $urandom;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    read_enable = 1'b1;
    addr_read = a;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    @(negedge clock);
    read_enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit b2b);
    exp_q.push_back(b);
    b2b_q.push_back(b2b);
    bus_write(2'd0, 4'b0001, {$urandom_range(0, 65535), 8'd0, b});
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mon_busy) break;
      @(negedge clock);
    end
    if (i >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d frames pending, required 0", exp_q.size());
      exp_q.delete();
      b2b_q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin : stim
    logic [31:0] r;
    logic [15:0] d;
    int          len, i;
    bit          tx_quiet;
    reset = 1'b1;
    write_enable = 1'b0;
    read_enable = 1'b0;
    mem_mask_write = 4'd0;
    addr_write = 2'd0;
    addr_read = 2'd0;
    data_in = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_tx", 32'(uart_tx), 32'd1);
    check("reset_dout", data_out, 32'd0);
    bus_read(2'd1, 32'h0000_0002, "reset_status");
    bus_read(2'd2, 32'd868, "reset_baud");

    bus_write(2'd2, 4'b0011, 32'd4);
    send_byte(8'hA5, 1'b0);
    @(negedge clock);
    check("tx_before_start", 32'(uart_tx), 32'd1);
    @(negedge clock);
    check("tx_start_low", 32'(uart_tx), 32'd0);
    wait_drain(200);
    bus_read(2'd1, 32'h0000_0002, "idle_status");
    repeat (3) @(negedge clock);
    check("dout_hold", data_out, 32'h0000_0002);

    bus_write(2'd0, 4'b0010, 32'h0000_005A);
    repeat (4) @(negedge clock);
    bus_read(2'd1, 32'h0000_0002, "mask_nopush");
    bus_read(2'd0, 32'd0, "txdata_reads0");

    bus_write(2'd2, 4'b0001, 32'hFFFF_FF03);
    bus_read(2'd2, 32'h0000_0003, "baud_lane0");
    bus_write(2'd2, 4'b0010, 32'h0000_0100);
    bus_read(2'd2, 32'h0000_0103, "baud_lane1");
    bus_write(2'd2, 4'b0011, 32'd4);

    // Ten back-to-back stores: one goes straight to the FSM, eight fill the FIFO, the last is dropped.
    for (i = 0; i < 9; i++) send_byte(8'($urandom), i != 0);
    bus_write(2'd0, 4'b0001, 32'h0000_00EE);
    bus_read(2'd1, 32'h0000_080D, "ovf_status");
    bus_write(2'd1, 4'b0001, 32'h0000_0008);
    bus_read(2'd1, 32'h0000_0805, "ovf_clear");
    wait_drain(600);
    bus_read(2'd1, 32'h0000_0002, "drained_status");

`ifdef UART_TX_IRQ_EN
    bus_write(2'd3, 4'b0001, 32'd1);
    bus_read(2'd3, 32'd1, "reg3");
    repeat (2) @(negedge clock);
    check("irq_idle", 32'(irq), 32'd1);
    send_byte(8'h3C, 1'b0);
    @(negedge clock);
    check("irq_drop", 32'(irq), 32'd0);
    wait_drain(200);
    check("irq_back", 32'(irq), 32'd1);
    bus_write(2'd3, 4'b0001, 32'd0);
`else
    bus_write(2'd3, 4'b0001, 32'd1);
    bus_read(2'd3, 32'd0, "reg3");
`endif

    for (int it = 0; it < 6; it++) begin
      d = (it == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      r = $urandom;
      bus_write(2'd2, 4'b0011, {r[31:16], d});
      bus_read(2'd2, {16'd0, d}, "rand_baud");
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) send_byte(8'($urandom), k != 0);
      wait_drain(len * 70 + 50);
      bus_read(2'd1, 32'h0000_0002, "rand_idle_status");
    end

    bus_write(2'd2, 4'b0011, 32'd4);
    mon_en = 1'b0;
    bus_write(2'd0, 4'b0001, 32'h0000_003C);
    bus_write(2'd0, 4'b0001, 32'h0000_00C3);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_div = 16'd868;
    check("rst_mid_tx", 32'(uart_tx), 32'd1);
    bus_read(2'd1, 32'h0000_0002, "rst_mid_status");
    tx_quiet = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) tx_quiet = 1'b0;
    end
    check("rst_no_frame", 32'(tx_quiet), 32'd1);
    mon_en = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
